// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the control unit (master) and the mul/div unit (slave).
interface hilo_muldiv_if #(
    parameter int unsigned WIDTH = hilo_muldiv_pkg::WIDTH
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI_out;
    logic [WIDTH-1:0] LO_out;
    logic             HI_Ld;
    logic             LO_Ld;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, HI_out, LO_out, HI_Ld, LO_Ld
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, HI_out, LO_out, HI_Ld, LO_Ld
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; used for |x| on entry and sign restore on exit.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val_c
);

    always_comb begin
        o_val_c = i_neg ? W'(~i_val + W'(1)) : i_val;
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply/divide producing HI/LO and their load strobes.
module hilo_muldiv #(
    parameter int unsigned WIDTH = hilo_muldiv_pkg::WIDTH,
    parameter int unsigned CNT_W = hilo_muldiv_pkg::CNT_W
) (
    input  logic          Clk,
    input  logic          Clr_n,
    hilo_muldiv_if.slave  bus
);
    import hilo_muldiv_pkg::*;

    localparam int unsigned W2 = 2 * WIDTH;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [W2-1:0]      r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;
    logic               r_hi_ld;
    logic               r_lo_ld;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    op_e                w_op;
    logic               w_in_div;
    logic               w_in_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [W2-1:0]      w_mul_acc;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [W2-1:0]      w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    always_comb begin
        w_op        = op_e'(bus.Op);
        w_in_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
        w_in_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    end

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .i_val   (bus.A),
        .i_neg   (w_in_signed & bus.A[WIDTH-1]),
        .o_val_c (w_abs_a)
    );

    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .i_val   (bus.B),
        .i_neg   (w_in_signed & bus.B[WIDTH-1]),
        .o_val_c (w_abs_b)
    );

    // One iteration: r_a supplies multiplier bits MSB-first, or dividend bits and collects quotient bits.
    always_comb begin
        w_mul_acc = {r_acc[W2-2:0], 1'b0} + (r_a[WIDTH-1] ? {{WIDTH{1'b0}}, r_b} : {W2{1'b0}});
        w_div_sh  = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
        w_div_ge  = (w_div_sh >= {1'b0, r_b});
        w_div_rem = w_div_ge ? WIDTH'(w_div_sh - {1'b0, r_b}) : w_div_sh[WIDTH-1:0];
    end

    muldiv_signfix #(.W(W2)) u_fix_prod (
        .i_val   (r_acc),
        .i_neg   (r_neg_q),
        .o_val_c (w_prod_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .i_val   (r_a),
        .i_neg   (r_neg_q),
        .o_val_c (w_quo_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .i_val   (r_acc[WIDTH-1:0]),
        .i_neg   (r_neg_r),
        .o_val_c (w_rem_fix)
    );

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi_ld   <= 1'b0;
            r_lo_ld   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi_ld   <= 1'b0;
            r_lo_ld   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_is_div <= w_in_div;
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_neg_q  <= w_in_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        r_neg_r  <= w_in_signed & w_in_div & bus.A[WIDTH-1];
                        r_dz     <= w_in_div & (bus.B == '0);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= {{WIDTH{1'b0}}, w_div_rem};
                        r_a   <= {r_a[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_acc;
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_divzero <= r_dz;
                    r_hi_ld   <= ~r_dz;
                    r_lo_ld   <= ~r_dz;
                    // A zero divisor leaves the previous results on HI_out/LO_out.
                    if (!r_dz) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[W2-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.DivZero = r_divzero;
    assign bus.HI_Ld   = r_hi_ld;
    assign bus.LO_Ld   = r_lo_ld;
    assign bus.HI_out  = r_hi;
    assign bus.LO_out  = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    hilo_muldiv_if #(.WIDTH(32)) u_if ();

    hilo_muldiv #(.WIDTH(32), .CNT_W(5)) u_dut (
        .Clk   (clk),
        .Clr_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Present a request, let the next rising edge accept it, then scramble the operands.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.Start = 1'b1;
        u_if.Op    = op;
        u_if.A     = a;
        u_if.B     = b;
        @(posedge clk); #1;
        u_if.Start = 1'b0;
        u_if.A     = 32'hDEAD_BEEF;
        u_if.B     = 32'h0BAD_F00D;
    endtask

    // Returns the edge index (relative to accept) of the Done pulse, 0 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = u_if.Busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (u_if.Done) begin
                lat = k;
                break;
            end
            if (u_if.Busy) busy_n++;
        end
    endtask

    int lat;
    int busy_n;
    int done_n;
    int first_lat;
    logic [63:0] res_at_done;

    initial begin
        rst_n      = 1'b0;
        u_if.Start = 1'b0;
        u_if.Op    = 2'b00;
        u_if.A     = '0;
        u_if.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {59'd0, u_if.Busy, u_if.Done, u_if.DivZero, u_if.HI_Ld, u_if.LO_Ld}, 64'd0);
        check("reset_hilo", {u_if.HI_out, u_if.LO_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULTU max * max
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, busy_n);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy_cycles", 64'(busy_n), 64'd33);
        check("multu_busy_done_cycle", {63'd0, u_if.Busy}, 64'd0);
        check("multu_res", {u_if.HI_out, u_if.LO_out}, 64'hFFFF_FFFE_0000_0001);
        check("multu_ld", {61'd0, u_if.HI_Ld, u_if.LO_Ld, u_if.DivZero}, 64'b110);
        @(posedge clk); #1;
        check("multu_pulse_end", {61'd0, u_if.Done, u_if.HI_Ld, u_if.LO_Ld}, 64'd0);
        check("multu_hold", {u_if.HI_out, u_if.LO_out}, 64'hFFFF_FFFE_0000_0001);

        // MULT -3 * 5, then DIVU 7/2 issued in the Done cycle
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, busy_n);
        check("mult_lat", 64'(lat), 64'd33);
        check("mult_res", {u_if.HI_out, u_if.LO_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        launch(2'b11, 32'd7, 32'd2);
        check("b2b_accepted", {62'd0, u_if.Busy, u_if.Done}, 64'b10);
        wait_done(lat, busy_n);
        check("divu_lat", 64'(lat), 64'd33);
        check("divu_res", {u_if.HI_out, u_if.LO_out}, {32'd1, 32'd3});

        // DIV -7/2 and the overflow case
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy_n);
        check("div_neg_res", {u_if.HI_out, u_if.LO_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy_n);
        check("div_ovf_res", {u_if.HI_out, u_if.LO_out}, 64'h0000_0000_8000_0000);

        // Divide by zero
        launch(2'b11, 32'h0000_1234, 32'd0);
        wait_done(lat, busy_n);
        check("dz_lat", 64'(lat), 64'd33);
        check("dz_flags", {60'd0, u_if.Done, u_if.DivZero, u_if.HI_Ld, u_if.LO_Ld}, 64'b1100);
        @(posedge clk); #1;
        check("dz_pulse_end", {62'd0, u_if.Done, u_if.DivZero}, 64'd0);

        // Start re-pulsed mid-run must be ignored
        launch(2'b01, 32'd6, 32'd7);
        done_n      = 0;
        first_lat   = 0;
        res_at_done = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                u_if.Start = 1'b1;
                u_if.Op    = 2'b11;
                u_if.A     = 32'd100;
                u_if.B     = 32'd9;
            end
            if (k == 6) u_if.Start = 1'b0;
            if (u_if.Done) begin
                done_n++;
                if (first_lat == 0) begin
                    first_lat   = k;
                    res_at_done = {u_if.HI_out, u_if.LO_out};
                end
            end
        end
        check("ignore_done_count", 64'(done_n), 64'd1);
        check("ignore_lat", 64'(first_lat), 64'd33);
        check("ignore_res", res_at_done, {32'd0, 32'd42});

        // Asynchronous reset mid-run
        launch(2'b01, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("clr_busy_drop", {63'd0, u_if.Busy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (u_if.Done || u_if.HI_Ld || u_if.LO_Ld) done_n++;
        end
        check("clr_no_done", 64'(done_n), 64'd0);
        launch(2'b01, 32'd3, 32'd4);
        wait_done(lat, busy_n);
        check("post_clr_lat", 64'(lat), 64'd33);
        check("post_clr_res", {u_if.HI_out, u_if.LO_out}, 64'd12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
